// File: rtl/fp32_pkg.sv
// Shared constants and enums for the float32 -> int32 converter.
// FP2INT_ROUND_NEAREST_EN (in the top) selects round-to-nearest-even instead of truncation.
package fp32_pkg;

    localparam int unsigned FRAC_W = 23;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MAG_W  = 24;

    localparam logic [EXP_W-1:0] EXP_BIAS      = 8'd127;
    localparam logic [EXP_W-1:0] INT_ALIGN_EXP = 8'd150;
    localparam logic [EXP_W-1:0] EXP_SAT       = 8'd158;
    localparam logic [EXP_W-1:0] EXP_SPECIAL   = 8'hFF;
    // Largest exponent whose magnitude is below 0.5.
    localparam logic [EXP_W-1:0] EXP_TINY_MAX  = EXP_BIAS - 8'd2;

    localparam logic [31:0] INT_MAX    = 32'h7FFF_FFFF;
    localparam logic [31:0] INT_MIN    = 32'h8000_0000;
    localparam logic [31:0] FP_INT_MIN = 32'hCF00_0000;

    typedef enum logic [2:0] {
        ClsZero, ClsTiny, ClsNormal, ClsSat, ClsInf, ClsNan
    } fp_class_e;

    typedef enum logic [1:0] {
        StIdle, StShift, StRound, StDone
    } state_e;

    function automatic logic [31:0] sat_by_sign(input logic sign);
        return sign ? INT_MIN : INT_MAX;
    endfunction

endpackage

// File: rtl/fp32_classify.sv
// Combinational unpack of a float32: class, alignment shift amount and direction.
module fp32_classify
    import fp32_pkg::*;
(
    input  logic [31:0] i_a,
    output fp_class_e   o_cls,
    output logic        o_sign,
    output logic [4:0]  o_shamt,
    output logic        o_left
);

    logic [EXP_W-1:0]  w_exp;
    logic [FRAC_W-1:0] w_frac;
    logic [EXP_W-1:0]  w_diff_l;
    logic [EXP_W-1:0]  w_diff_r;

    assign o_sign   = i_a[31];
    assign w_exp    = i_a[30:23];
    assign w_frac   = i_a[22:0];
    assign w_diff_l = w_exp - INT_ALIGN_EXP;
    assign w_diff_r = INT_ALIGN_EXP - w_exp;

    always_comb begin
        o_cls   = ClsZero;
        o_shamt = 5'd0;
        o_left  = 1'b0;
        if (w_exp == EXP_SPECIAL) begin
            o_cls = (w_frac != '0) ? ClsNan : ClsInf;
        end else if (w_exp >= EXP_SAT) begin
            o_cls = ClsSat;
        end else if (w_exp == '0) begin
            o_cls = ClsZero;
        end else if (w_exp <= EXP_TINY_MAX) begin
            o_cls = ClsTiny;
        end else begin
            o_cls = ClsNormal;
            if (w_exp > INT_ALIGN_EXP) begin
                o_left  = 1'b1;
                o_shamt = w_diff_l[4:0];
            end else begin
                o_shamt = w_diff_r[4:0];
            end
        end
    end

endmodule

// File: rtl/fp32_to_int32_seq.sv
// Iterative float32 -> int32 converter: classify, multi-cycle align, round, negate, saturate.
// Define FP2INT_ROUND_NEAREST_EN for round-to-nearest-even; default truncates toward zero.
module fp32_to_int32_seq
    import fp32_pkg::*;
#(
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] A,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] S,
    output logic        overflow,
    output logic        invalid,
    output logic        inexact
);

    localparam logic [4:0] STEP = 5'(SHIFT_STEP);

    state_e      r_state, w_state_d;
    logic [31:0] r_mag, w_mag_d;
    logic        r_guard, w_guard_d;
    logic        r_sticky, w_sticky_d;
    logic [4:0]  r_rem, w_rem_d;
    logic        r_left, w_left_d;
    logic        r_sign, w_sign_d;
    logic [31:0] r_s, w_s_d;
    logic        r_ovf, w_ovf_d;
    logic        r_inv, w_inv_d;
    logic        r_inx, w_inx_d;

    fp_class_e   w_cls;
    logic        w_sign;
    logic [4:0]  w_shamt;
    logic        w_left;

    fp32_classify u_classify (
        .i_a     (A),
        .o_cls   (w_cls),
        .o_sign  (w_sign),
        .o_shamt (w_shamt),
        .o_left  (w_left)
    );

    logic [4:0]  w_step;
    logic [32:0] w_ext;
    logic [32:0] w_ext_sh;
    logic [32:0] w_lost_mask;
    logic        w_lost;
    logic        w_inc;
    logic [31:0] w_mag_rnd;
    logic [31:0] w_res;

    assign w_step      = (r_rem < STEP) ? r_rem : STEP;
    // {mag, guard}: after a right shift bit 0 is the new guard, everything below it is sticky.
    assign w_ext       = {r_mag, r_guard};
    assign w_ext_sh    = w_ext >> w_step;
    assign w_lost_mask = (33'd1 << w_step) - 33'd1;
    assign w_lost      = |(w_ext & w_lost_mask);

`ifdef FP2INT_ROUND_NEAREST_EN
    assign w_inc = r_guard & (r_sticky | r_mag[0]);
`else
    assign w_inc = 1'b0;
`endif

    assign w_mag_rnd = r_mag + {31'd0, w_inc};
    assign w_res     = r_sign ? (32'd0 - w_mag_rnd) : w_mag_rnd;

    always_comb begin
        w_state_d  = r_state;
        w_mag_d    = r_mag;
        w_guard_d  = r_guard;
        w_sticky_d = r_sticky;
        w_rem_d    = r_rem;
        w_left_d   = r_left;
        w_sign_d   = r_sign;
        w_s_d      = r_s;
        w_ovf_d    = r_ovf;
        w_inv_d    = r_inv;
        w_inx_d    = r_inx;
        unique case (r_state)
            StIdle: begin
                if (in_valid) begin
                    w_sign_d   = w_sign;
                    w_mag_d    = {8'd0, 1'b1, A[FRAC_W-1:0]};
                    w_guard_d  = 1'b0;
                    w_sticky_d = 1'b0;
                    w_rem_d    = w_shamt;
                    w_left_d   = w_left;
                    w_ovf_d    = 1'b0;
                    w_inv_d    = 1'b0;
                    w_inx_d    = 1'b0;
                    w_state_d  = StDone;
                    unique case (w_cls)
                        ClsNan: begin
                            w_s_d   = INT_MAX;
                            w_inv_d = 1'b1;
                        end
                        ClsInf: begin
                            w_s_d   = sat_by_sign(w_sign);
                            w_ovf_d = 1'b1;
                        end
                        ClsSat: begin
                            w_s_d   = sat_by_sign(w_sign);
                            w_ovf_d = (A != FP_INT_MIN);
                        end
                        ClsZero: begin
                            w_s_d   = 32'd0;
                            w_inx_d = (A[FRAC_W-1:0] != '0);
                        end
                        ClsTiny: begin
                            w_s_d   = 32'd0;
                            w_inx_d = 1'b1;
                        end
                        ClsNormal: w_state_d = (w_shamt == 5'd0) ? StRound : StShift;
                        default:   w_state_d = StDone;
                    endcase
                end
            end
            StShift: begin
                if (r_left) begin
                    w_mag_d = r_mag << w_step;
                end else begin
                    w_mag_d    = w_ext_sh[32:1];
                    w_guard_d  = w_ext_sh[0];
                    w_sticky_d = r_sticky | w_lost;
                end
                w_rem_d = r_rem - w_step;
                if (r_rem == w_step) begin
                    w_state_d = StRound;
                end
            end
            StRound: begin
                w_s_d     = w_res;
                w_inx_d   = r_guard | r_sticky;
                w_state_d = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_mag    <= '0;
            r_guard  <= 1'b0;
            r_sticky <= 1'b0;
            r_rem    <= '0;
            r_left   <= 1'b0;
            r_sign   <= 1'b0;
            r_s      <= '0;
            r_ovf    <= 1'b0;
            r_inv    <= 1'b0;
            r_inx    <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_mag    <= w_mag_d;
            r_guard  <= w_guard_d;
            r_sticky <= w_sticky_d;
            r_rem    <= w_rem_d;
            r_left   <= w_left_d;
            r_sign   <= w_sign_d;
            r_s      <= w_s_d;
            r_ovf    <= w_ovf_d;
            r_inv    <= w_inv_d;
            r_inx    <= w_inx_d;
        end
    end

    assign in_ready  = (r_state == StIdle);
    assign out_valid = (r_state == StDone);
    assign S         = r_s;
    assign overflow  = r_ovf;
    assign invalid   = r_inv;
    assign inexact   = r_inx;

endmodule

// File: tb/tb_fp32_to_int32_seq.sv
// Bench for fp32_to_int32_seq: directed vector table, handshake/reset sequences, random vs model.
module tb_fp32_to_int32_seq;

    localparam int unsigned SHIFT_STEP = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] A = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] S;
    logic        overflow;
    logic        invalid;
    logic        inexact;

    int n_tests = 0;
    int n_fail  = 0;

    fp32_to_int32_seq #(.SHIFT_STEP(SHIFT_STEP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .overflow  (overflow),
        .invalid   (invalid),
        .inexact   (inexact)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] s;
        logic        ovf;
        logic        inv;
        logic        inx;
        int          lat;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    // Value-level model: integer part and remainder of {1,frac} * 2^(exp-150).
    task automatic ref_model(input logic [31:0] a, output logic [31:0] s, output logic ovf,
                             output logic inv, output logic inx, output int lat);
        int     e;
        int     n;
        longint mant, q, r, half;
        e   = int'(a[30:23]);
        s   = 32'd0;
        ovf = 1'b0;
        inv = 1'b0;
        inx = 1'b0;
        lat = 1;
        if (e == 255) begin
            if (a[22:0] != 23'd0) begin
                s   = 32'h7FFF_FFFF;
                inv = 1'b1;
            end else begin
                s   = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
                ovf = 1'b1;
            end
        end else if (e >= 158) begin
            s   = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            ovf = (a != 32'hCF00_0000);
        end else if (e == 0) begin
            inx = (a[22:0] != 23'd0);
        end else if (e <= 125) begin
            inx = 1'b1;
        end else begin
            mant = longint'({1'b1, a[22:0]});
            if (e >= 150) begin
                n = e - 150;
                q = mant <<< n;
                r = 0;
                half = 0;
            end else begin
                n = 150 - e;
                q = mant >>> n;
                r = mant - (q <<< n);
                half = longint'(1) <<< (n - 1);
            end
            inx = (r != 0);
`ifdef FP2INT_ROUND_NEAREST_EN
            if (n > 0 && e < 150 && (r > half || (r == half && q[0]))) q = q + 1;
`endif
            s   = a[31] ? 32'(-q) : 32'(q);
            lat = 2 + (n + int'(SHIFT_STEP) - 1) / int'(SHIFT_STEP);
        end
    endtask

    task automatic run_vec(input string nm, input logic [31:0] a, input logic [31:0] es,
                           input logic eo, input logic ei, input logic ex, input int el);
        int c;
        c = 0;
        while (!in_ready && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk({nm, " in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        A = a;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        c = 0;
        while (!out_valid && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk({nm, " S"}, S, es);
        chk({nm, " overflow"}, {31'd0, overflow}, {31'd0, eo});
        chk({nm, " invalid"}, {31'd0, invalid}, {31'd0, ei});
        chk({nm, " inexact"}, {31'd0, inexact}, {31'd0, ex});
        chk({nm, " latency"}, 32'(c + 1), 32'(el));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    vec_t vecs[$];

    initial begin
        logic [31:0] es;
        logic        eo, ei, ex;
        int          el;
        logic [31:0] a;
        logic [31:0] s_hold;
        int          c;

`ifdef FP2INT_ROUND_NEAREST_EN
        vecs.push_back('{32'h3FC0_0000, 32'd2, 1'b0, 1'b0, 1'b1, 25});
        vecs.push_back('{32'h4060_0000, 32'd4, 1'b0, 1'b0, 1'b1, 24});
        vecs.push_back('{32'hBF40_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 26});
`else
        vecs.push_back('{32'h3FC0_0000, 32'd1, 1'b0, 1'b0, 1'b1, 25});
        vecs.push_back('{32'h4060_0000, 32'd3, 1'b0, 1'b0, 1'b1, 24});
        vecs.push_back('{32'hBF40_0000, 32'd0, 1'b0, 1'b0, 1'b1, 26});
`endif
        vecs.push_back('{32'h4020_0000, 32'd2, 1'b0, 1'b0, 1'b1, 24});
        vecs.push_back('{32'hC2F6_E979, 32'hFFFF_FF85, 1'b0, 1'b0, 1'b1, 19});
        vecs.push_back('{32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0, 1'b0, 9});
        vecs.push_back('{32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{32'h7FC0_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1});
        vecs.push_back('{32'h8000_0000, 32'd0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{32'h3E80_0000, 32'd0, 1'b0, 1'b0, 1'b1, 1});
        vecs.push_back('{32'h3F80_0000, 32'd1, 1'b0, 1'b0, 1'b0, 25});
        vecs.push_back('{32'h4B00_0001, 32'h0080_0001, 1'b0, 1'b0, 1'b0, 2});
        vecs.push_back('{32'h0000_0001, 32'd0, 1'b0, 1'b0, 1'b1, 1});

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset S", S, 32'd0);
        chk("reset flags", {29'd0, overflow, invalid, inexact}, 32'd0);

        foreach (vecs[i]) begin
            run_vec($sformatf("vec%0d", i), vecs[i].a, vecs[i].s, vecs[i].ovf, vecs[i].inv,
                    vecs[i].inx, vecs[i].lat);
        end

        // Backpressure: hold DONE for 5 cycles while a new operand is offered.
        in_valid = 1'b1;
        A = 32'hC2F6_E979;
        @(posedge clk);
        @(negedge clk);
        A = 32'h4F00_0000;
        c = 0;
        while (!out_valid && c < 200) begin
            @(negedge clk);
            c++;
        end
        s_hold = S;
        chk("bp S", s_hold, 32'hFFFF_FF85);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp stable S", S, s_hold);
            chk("bp out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp flags", {29'd0, overflow, invalid, inexact}, 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp drop out_valid", {31'd0, out_valid}, 32'd0);
        chk("bp idle in_ready", {31'd0, in_ready}, 32'd1);

        // Reset while shifting aborts the conversion.
        in_valid = 1'b1;
        A = 32'h4A00_0001;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst mid out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst mid S", S, 32'd0);
        chk("rst mid in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst mid flags", {29'd0, overflow, invalid, inexact}, 32'd0);
        c = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (out_valid) c++;
        end
        chk("rst mid no result", 32'(c), 32'd0);

        for (int i = 0; i < 300; i++) begin
            if (i % 3 == 0) a = $urandom;
            else a = {1'($urandom), 8'($urandom_range(160, 120)), 23'($urandom)};
            ref_model(a, es, eo, ei, ex, el);
            run_vec($sformatf("rand a=%h", a), a, es, eo, ei, ex, el);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
